// File: rtl/cs_addsub_pkg.sv
// cs_addsub_pkg: shared types and sizing helpers for the pipelined
// carry-select adder/subtractor.
package cs_addsub_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Number of carry-select blocks across the operand.
   function automatic int NBLK_F(input int width, input int blk);
      return width / blk;
   endfunction

   // Number of pipeline stages; the last stage may hold fewer blocks.
   function automatic int NSTG_F(input int nblk, input int blk_per_stg);
      return (nblk + blk_per_stg - 1) / blk_per_stg;
   endfunction

endpackage

// File: rtl/cs_addsub_if.sv
// cs_addsub_if: valid/ready operand and result streams of cs_addsub_pipe.
// master drives operands and accepts results; slave is the datapath.
interface cs_addsub_if #(
   parameter int WIDTH = 20
);

   logic             in_valid;
   logic             in_ready;
   logic             mode_sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             co;
   logic             ovf;

   modport master (
      output in_valid, mode_sub, a, b, out_ready,
      input  in_ready, out_valid, s, co, ovf
   );

   modport slave (
      input  in_valid, mode_sub, a, b, out_ready,
      output in_ready, out_valid, s, co, ovf
   );

endinterface

// File: rtl/cs_sel_block.sv
// cs_sel_block: one carry-select slice. Both candidate sums (ci=0, ci=1)
// are formed in parallel; the incoming carry only drives the final mux.
module cs_sel_block #(
   parameter int BLK = 4
) (
   input  logic [BLK-1:0] a,
   input  logic [BLK-1:0] b,
   input  logic           ci,
   output logic [BLK-1:0] s,
   output logic           co
);

   logic [BLK:0] sum0;
   logic [BLK:0] sum1;

   assign sum0 = {1'b0, a} + {1'b0, b};
   assign sum1 = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};

   assign {co, s} = ci ? sum1 : sum0;

endmodule

// File: rtl/cs_addsub_pipe.sv
// cs_addsub_pipe: pipelined carry-select adder/subtractor with valid/ready
// streaming and a global stall. Each stage resolves BLK_PER_STG blocks and
// forwards the resolved sum bits, the running carry and the remaining
// (already mode-inverted) operand bits to the next stage.
// Build option: APPROX_ADD_EN makes the low APPROX_BITS an OR of the
// operands with no carry out of that region and no +1 carry-in.
module cs_addsub_pipe
   import cs_addsub_pkg::*;
#(
   parameter int WIDTH       = 20,
   parameter int BLK         = 4,
   parameter int BLK_PER_STG = 2,
   parameter int APPROX_BITS = 4
) (
   input logic       clk,
   input logic       rst,
   cs_addsub_if.slave bus
);

   localparam int NBLK = NBLK_F(WIDTH, BLK);
   localparam int NSTG = NSTG_F(NBLK, BLK_PER_STG);
`ifdef APPROX_ADD_EN
   localparam int NAPX = APPROX_BITS / BLK;
   localparam bit APX  = 1'b1;
`else
   localparam int NAPX = 0;
   localparam bit APX  = 1'b0;
`endif

   if (WIDTH % BLK != 0) begin : g_chk_width
      $error("cs_addsub_pipe: WIDTH must be a multiple of BLK");
   end
   if ((APPROX_BITS % BLK != 0) || (APPROX_BITS >= WIDTH)) begin : g_chk_approx
      $error("cs_addsub_pipe: APPROX_BITS must be a multiple of BLK and below WIDTH");
   end

   op_e  op_in;
   logic inv;
   logic adv;
   logic ovf_d;
   logic ovf_q;

   // Per-stage register outputs, gathered so each stage can read its predecessor.
   logic [NSTG-1:0][WIDTH-1:0] st_s;
   logic [NSTG-1:0][WIDTH-1:0] st_a;
   logic [NSTG-1:0][WIDTH-1:0] st_b;
   logic [NSTG-1:0]            st_c;
   logic [NSTG-1:0]            st_v;

   assign op_in = op_e'(bus.mode_sub);
   assign inv   = (op_in == OP_SUB);

   // Global stall: the whole pipe moves only when the output slot is free.
   assign adv          = ~st_v[NSTG-1] | bus.out_ready;
   assign bus.in_ready = adv;

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      localparam int FB = k * BLK_PER_STG;
      localparam int NB = ((FB + BLK_PER_STG) <= NBLK) ? BLK_PER_STG : (NBLK - FB);

      logic [WIDTH-1:0]  op_a;
      logic [WIDTH-1:0]  op_b;
      logic [WIDTH-1:0]  s_in;
      logic              op_c;
      logic              v_in;
      logic [NB:0]       cy;
      logic [NB*BLK-1:0] sb;
      logic [WIDTH-1:0]  s_d;
      logic [WIDTH-1:0]  s_q;
      logic [WIDTH-1:0]  a_q;
      logic [WIDTH-1:0]  b_q;
      logic              c_d;
      logic              c_q;
      logic              v_q;

      if (k == 0) begin : g_in
         assign op_a = bus.a;
         assign op_b = bus.b ^ {WIDTH{inv}};
         assign op_c = inv & ~APX;
         assign s_in = '0;
         assign v_in = bus.in_valid & adv;
      end else begin : g_in
         assign op_a = st_a[k-1];
         assign op_b = st_b[k-1];
         assign op_c = st_c[k-1];
         assign s_in = st_s[k-1];
         assign v_in = st_v[k-1];
      end

      assign cy[0] = op_c;

      for (genvar i = 0; i < NB; i++) begin : g_blk
         localparam int J = FB + i;
         if (J < NAPX) begin : g_apx
            assign sb[i*BLK +: BLK] = op_a[J*BLK +: BLK] | op_b[J*BLK +: BLK];
            assign cy[i+1]          = 1'b0;
         end else begin : g_exact
            cs_sel_block #(
               .BLK (BLK)
            ) u_blk (
               .a  (op_a[J*BLK +: BLK]),
               .b  (op_b[J*BLK +: BLK]),
               .ci (cy[i]),
               .s  (sb[i*BLK +: BLK]),
               .co (cy[i+1])
            );
         end
      end

      // Merge this stage's resolved bits into the partial sum.
      always_comb begin
         s_d                      = s_in;
         s_d[FB*BLK +: NB*BLK]    = sb;
         c_d                      = cy[NB];
      end

      // Stage register: shifts on adv, holds on stall, cleared by reset.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s_q <= '0;
            a_q <= '0;
            b_q <= '0;
            c_q <= 1'b0;
            v_q <= 1'b0;
         end else if (adv) begin
            s_q <= s_d;
            a_q <= op_a;
            b_q <= op_b;
            c_q <= c_d;
            v_q <= v_in;
         end
      end

      assign st_s[k] = s_q;
      assign st_a[k] = a_q;
      assign st_b[k] = b_q;
      assign st_c[k] = c_q;
      assign st_v[k] = v_q;

      if (k == NSTG - 1) begin : g_ovf
         // Carry into the MSB recovered from the MSB sum bit and its operands.
         assign ovf_d = (s_d[WIDTH-1] ^ op_a[WIDTH-1] ^ op_b[WIDTH-1]) ^ cy[NB];
      end
   end

   // Overflow flag travels with the last stage register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (adv) begin
         ovf_q <= ovf_d;
      end
   end

   assign bus.out_valid = st_v[NSTG-1];
   assign bus.s         = st_s[NSTG-1];
   assign bus.co        = st_c[NSTG-1];
   assign bus.ovf       = ovf_q;

endmodule
